pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the instruction-fetch stage. It holds the fetch PC, issues one fetch address per cycle to instruction memory over a valid/ready handshake, and computes the sequential successor internally as PC + `increment`, modulo 2^`width`. It applies redirects from the branch/jump resolution logic, and exports the return-link value (issued PC + increment) alongside each issued address for the IF/ID register.

## Interface
- `width`, 10: PC/address width in bits.
- `increment`, 1: sequential step added to PC; word-addressed instruction memory.
- `reset_vector`, 0: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `fetch_ready` input 1: instruction memory / IF-ID register accepts the current address.
- `redirect` input 1: branch taken or jump resolved this cycle.
- `redirect_target` input `width`: new PC when `redirect`=1.
- `halt_req` input 1: stop issuing fetches (halt instruction decoded).
- `resume` input 1: leave HALT at the held PC.
- `pc` output `width`: current fetch address, registered.
- `pc_link` output `width`: `pc` + `increment`, registered with `pc`.
- `fetch_valid` output 1: `pc` is a valid fetch request.
- `flush` output 1: one-cycle pulse; IF/ID must discard its contents.
- `halted` output 1: sequencer is in HALT.
- `wrap_trap` output 1: sticky; exists only with `PC_WRAP_TRAP_EN` (see Configuration).

## Operation
- States: BOOT, RUN, HALT. Encoding is free; there are no other states.
- Reset (async, any state): state=BOOT, `pc`=`reset_vector`, `pc_link`=`reset_vector`+`increment` (truncated), `fetch_valid`=0, `flush`=0, `halted`=0, `wrap_trap`=0.
- BOOT: lasts exactly one cycle after `rst` falls, with `fetch_valid`=0. It always goes to RUN. A `redirect` or `halt_req` arriving in BOOT is ignored.
- RUN: `fetch_valid`=1. Each cycle, apply the first matching rule, highest priority first:
  1. `redirect`: `pc`←`redirect_target`, `pc_link`←target+`increment`, `flush`←1 next cycle. Applies whether or not `fetch_ready` is high.
  2. `halt_req`: go to HALT. `pc` is held; `fetch_valid`←0.
  3. `fetch_ready`=0 (stall): hold `pc`, `pc_link`, `fetch_valid`.
  4. `fetch_ready`=1: `pc`←`pc_link`, `pc_link`←`pc_link`+`increment`.
- HALT: `fetch_valid`=0, `halted`=1; `fetch_ready` is ignored.
  - `redirect`: load target, go to RUN, pulse `flush`.
  - `resume` without `redirect`: go to RUN at the held `pc`; no flush.
  - `redirect` and `resume` together: treated as a redirect.
- Arithmetic: every addition is `width` bits, unsigned, carry discarded. The PC wraps from 2^`width`−`increment` (and above) back to low addresses.
- Handshake: a request transfers on a cycle where `fetch_valid`=1 and `fetch_ready`=1. While stalled, `pc` stays stable until the request transfers or a redirect occurs. Only a redirect may withdraw an outstanding request.

## Timing
- Every output is a register; there are no combinational paths from inputs to outputs.
- Redirect asserted in cycle N: `pc`=target and `flush`=1 in cycle N+1; `flush`=0 in N+2 unless another redirect occurs.
- Back-to-back redirects: each one loads its target; `flush` stays high continuously.
- Sequential throughput: one address per cycle while `fetch_ready`=1.
- `halt_req` in cycle N: `fetch_valid`=0 and `halted`=1 from cycle N+1. `resume` in cycle M: `fetch_valid`=1 and `halted`=0 from cycle M+1.
- Reset asserted mid-stall or mid-flush: outputs return to reset values immediately, with no clock edge required.

## Configuration
- `PC_WRAP_TRAP_EN` defined:
  - A sequential increment (rule 4) whose sum carries out of `width` bits does not update `pc`. Instead the sequencer sets `wrap_trap`=1 (sticky until reset) and enters HALT.
  - A redirect to any address is still accepted, including from the trapped state.
- `PC_WRAP_TRAP_EN` undefined:
  - Silent wrap-around.
  - The `wrap_trap` port is absent and no trap logic is generated.

## Test plan
- Reset, then release with `fetch_ready`=1, defaults: BOOT cycle with `fetch_valid`=0, then `pc`=0,1,2,3 on consecutive cycles, with `pc_link` always one ahead.
- Stall: `fetch_ready`=0 for 3 cycles at `pc`=5 -> `pc` stays 5 and `fetch_valid` stays 1; after `fetch_ready` returns to 1, `pc`=6 the next cycle.
- Redirect during stall: `pc`=7, `fetch_ready`=0, `redirect`=1, target=0x200 -> next cycle `pc`=0x200, `pc_link`=0x201, `flush`=1; the following cycle `flush`=0.
- Halt and resume: `halt_req` at `pc`=9 -> `halted`=1 and `fetch_valid`=0, `pc` held at 9. `resume` -> `pc`=9 and `fetch_valid`=1 next cycle, with no flush. Assert `redirect`+`resume` in HALT -> target loaded and `flush`=1.
- Wrap: `reset_vector`=0x3FE, `fetch_ready`=1 -> without the macro, `pc`=0x3FE, 0x3FF, 0x000. With `PC_WRAP_TRAP_EN`, `pc` holds 0x3FF, `wrap_trap`=1, `halted`=1.
- Async reset asserted mid-cycle while `flush`=1 -> all outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-address handshake between the PC sequencer and instruction memory.
// Optional trap flag is present only when PC_WRAP_TRAP_EN is defined.
interface pc_sequencer_if #(
    parameter int width = 10
);
    logic             fetch_ready;
    logic             redirect;
    logic [width-1:0] redirect_target;
    logic             halt_req;
    logic             resume;
    logic [width-1:0] pc;
    logic [width-1:0] pc_link;
    logic             fetch_valid;
    logic             flush;
    logic             halted;
`ifdef PC_WRAP_TRAP_EN
    logic             wrap_trap;
`endif

    modport master (
        input  fetch_ready, redirect, redirect_target, halt_req, resume,
`ifdef PC_WRAP_TRAP_EN
        output wrap_trap,
`endif
        output pc, pc_link, fetch_valid, flush, halted
    );

    modport slave (
        output fetch_ready, redirect, redirect_target, halt_req, resume,
`ifdef PC_WRAP_TRAP_EN
        input  wrap_trap,
`endif
        input  pc, pc_link, fetch_valid, flush, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT, redirects, stalls, return-link export.
// Define PC_WRAP_TRAP_EN to trap (and halt) on sequential wrap-around.
module pc_sequencer #(
    parameter int               width        = 10,
    parameter int               increment    = 1,
    parameter logic [width-1:0] reset_vector = '0
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master bus
);
    localparam logic [width-1:0] step      = width'(increment);
    localparam logic [width-1:0] boot_link = reset_vector + step;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t           state;
    logic [width-1:0] cur_pc;
    logic [width-1:0] cur_link;
    logic             valid;
    logic             flush_pulse;
    logic             halt_flag;

`ifdef PC_WRAP_TRAP_EN
    logic             trap;
    logic [width:0]   seq_sum;

    // Carry out of the sequential step means the next PC would wrap.
    assign seq_sum = {1'b0, cur_pc} + {1'b0, step};
    assign bus.wrap_trap = trap;
`endif

    assign bus.pc          = cur_pc;
    assign bus.pc_link     = cur_link;
    assign bus.fetch_valid = valid;
    assign bus.flush       = flush_pulse;
    assign bus.halted      = halt_flag;

    // Sequencer state, PC/link registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            cur_pc      <= reset_vector;
            cur_link    <= boot_link;
            valid       <= 1'b0;
            flush_pulse <= 1'b0;
            halt_flag   <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
            trap        <= 1'b0;
`endif
        end else begin
            flush_pulse <= 1'b0;
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    valid <= 1'b1;
                end
                RUN: begin
                    if (bus.redirect) begin
                        cur_pc      <= bus.redirect_target;
                        cur_link    <= bus.redirect_target + step;
                        flush_pulse <= 1'b1;
                    end else if (bus.halt_req) begin
                        state     <= HALT;
                        valid     <= 1'b0;
                        halt_flag <= 1'b1;
                    end else if (bus.fetch_ready) begin
`ifdef PC_WRAP_TRAP_EN
                        if (seq_sum[width]) begin
                            trap      <= 1'b1;
                            state     <= HALT;
                            valid     <= 1'b0;
                            halt_flag <= 1'b1;
                        end else begin
                            cur_pc   <= cur_link;
                            cur_link <= cur_link + step;
                        end
`else
                        cur_pc   <= cur_link;
                        cur_link <= cur_link + step;
`endif
                    end
                end
                HALT: begin
                    if (bus.redirect) begin
                        cur_pc      <= bus.redirect_target;
                        cur_link    <= bus.redirect_target + step;
                        flush_pulse <= 1'b1;
                        state       <= RUN;
                        valid       <= 1'b1;
                        halt_flag   <= 1'b0;
                    end else if (bus.resume) begin
                        state     <= RUN;
                        valid     <= 1'b1;
                        halt_flag <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a mode/PC model.
// Honours PC_WRAP_TRAP_EN when compiled with it.
module tb_pc_sequencer;
    localparam int MOD = 1024;
    localparam int INC = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_sequencer_if #(.width(10)) bus_a ();
    pc_sequencer_if #(.width(10)) bus_b ();

    pc_sequencer #(
        .width(10), .increment(1), .reset_vector(10'h000)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    pc_sequencer #(
        .width(10), .increment(1), .reset_vector(10'h3FE)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0=boot 1=run 2=halt, plain integer PC.
    int m_mode;
    int m_pc;
    bit m_flush;
    bit m_trap;
`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    function automatic void model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_flush = 0;
        m_trap  = 0;
    endfunction

    function automatic void model_step(bit rd, int tgt, bit hr, bit rs, bit fr);
        m_flush = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rd) begin
                m_pc = tgt; m_flush = 1;
            end else if (hr) begin
                m_mode = 2;
            end else if (fr) begin
                if (TRAP_EN && (m_pc + INC >= MOD)) begin
                    m_trap = 1; m_mode = 2;
                end else begin
                    m_pc = (m_pc + INC) % MOD;
                end
            end
        end else begin
            if (rd) begin
                m_pc = tgt; m_flush = 1; m_mode = 1;
            end else if (rs) begin
                m_mode = 1;
            end
        end
    endfunction

    function automatic logic [22:0] model_out();
        return {10'(m_pc), 10'((m_pc + INC) % MOD),
                m_mode == 1, m_flush, m_mode == 2};
    endfunction

    function automatic logic [22:0] obs_a();
        return {bus_a.pc, bus_a.pc_link, bus_a.fetch_valid,
                bus_a.flush, bus_a.halted};
    endfunction

    task automatic step_a(bit rd, int tgt, bit hr, bit rs, bit fr);
        bus_a.redirect        = rd;
        bus_a.redirect_target = 10'(tgt);
        bus_a.halt_req        = hr;
        bus_a.resume          = rs;
        bus_a.fetch_ready     = fr;
        @(posedge clk);
        model_step(rd, tgt, hr, rs, fr);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst = 1'b1;
        #1;
        got = obs_a();
        checks++;
        if (got !== 23'h000_004 << 1) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", got, 23'h000008);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        got = obs_a();
        checks++;
        if (got !== model_out() || got[2] !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle: got %h want %h", got, model_out());
        end
    endtask

    task automatic test_sequential();
        logic [22:0] got;
        for (int i = 0; i < 4; i++) begin
            step_a(0, 0, 0, 0, 1);
            got = obs_a();
            checks++;
            if (got !== model_out() || got[22:13] !== 10'(i)) begin
                errors++;
                $display("FAIL seq_pc%0d: got %h want %h", i, got, model_out());
            end
        end
    endtask

    task automatic test_stall();
        logic [22:0] got;
        step_a(0, 0, 0, 0, 1);
        step_a(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step_a(0, 0, 0, 0, 0);
            got = obs_a();
            checks++;
            if (got !== model_out() || got[22:13] !== 10'd5 || !got[2]) begin
                errors++;
                $display("FAIL stall_hold: got %h want %h", got, model_out());
            end
        end
        step_a(0, 0, 0, 0, 1);
        got = obs_a();
        checks++;
        if (got !== model_out() || got[22:13] !== 10'd6) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", got, model_out());
        end
    endtask

    task automatic test_redirect_stall();
        logic [22:0] got;
        step_a(0, 0, 0, 0, 1);
        step_a(1, 'h200, 0, 0, 0);
        got = obs_a();
        checks++;
        if (got !== model_out() || got !== {10'h200, 10'h201, 3'b110}) begin
            errors++;
            $display("FAIL redirect_stall: got %h want %h", got, model_out());
        end
        step_a(0, 0, 0, 0, 0);
        got = obs_a();
        checks++;
        if (got !== model_out() || got[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got %h want %h", got, model_out());
        end
        step_a(1, 'h3FF, 0, 0, 0);
        step_a(1, 'h3FC, 0, 0, 1);
        got = obs_a();
        checks++;
        if (got !== {10'h3FC, 10'h3FD, 3'b110}) begin
            errors++;
            $display("FAIL back_to_back: got %h want %h", got, model_out());
        end
    endtask

    task automatic test_halt_resume();
        logic [22:0] got;
        step_a(1, 9, 0, 0, 1);
        step_a(0, 0, 1, 0, 1);
        got = obs_a();
        checks++;
        if (got !== model_out() || got !== {10'd9, 10'd10, 3'b001}) begin
            errors++;
            $display("FAIL halt_entry: got %h want %h", got, model_out());
        end
        step_a(0, 0, 0, 0, 1);
        step_a(0, 0, 1, 0, 1);
        got = obs_a();
        checks++;
        if (got !== model_out() || got[22:13] !== 10'd9) begin
            errors++;
            $display("FAIL halt_hold: got %h want %h", got, model_out());
        end
        step_a(0, 0, 0, 1, 0);
        got = obs_a();
        checks++;
        if (got !== model_out() || got !== {10'd9, 10'd10, 3'b100}) begin
            errors++;
            $display("FAIL resume: got %h want %h", got, model_out());
        end
        step_a(0, 0, 1, 0, 1);
        step_a(1, 'h155, 0, 1, 0);
        got = obs_a();
        checks++;
        if (got !== model_out() || got !== {10'h155, 10'h156, 3'b110}) begin
            errors++;
            $display("FAIL redirect_resume: got %h want %h", got, model_out());
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] got;
        step_a(1, 'h3A, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        got = obs_a();
        checks++;
        if (got !== {10'h000, 10'h001, 3'b000}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", got, 23'h000008);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [22:0] got;
        int          bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step_a($urandom_range(7) == 0, int'($urandom_range(1023)),
                   $urandom_range(15) == 0, $urandom_range(3) == 0,
                   $urandom_range(3) != 0);
            got = obs_a();
            checks++;
            if (got !== model_out()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_%0d: got %h want %h", i, got, model_out());
                bad++;
            end
`ifdef PC_WRAP_TRAP_EN
            checks++;
            if (bus_a.wrap_trap !== m_trap) begin
                errors++;
                $display("FAIL random_trap_%0d: got %b want %b",
                         i, bus_a.wrap_trap, m_trap);
            end
`endif
        end
    endtask

    task automatic test_wrap();
        logic [22:0] got;
        bus_b.redirect        = 1'b0;
        bus_b.redirect_target = '0;
        bus_b.halt_req        = 1'b0;
        bus_b.resume          = 1'b0;
        bus_b.fetch_ready     = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        got = {bus_b.pc, bus_b.pc_link, bus_b.fetch_valid,
               bus_b.flush, bus_b.halted};
        checks++;
        if (got !== {10'h3FE, 10'h3FF, 3'b100}) begin
            errors++;
            $display("FAIL wrap_pc0: got %h", got);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_b.pc !== 10'h3FF || bus_b.pc_link !== 10'h000) begin
            errors++;
            $display("FAIL wrap_pc1: got %h want 3ff", bus_b.pc);
        end
        @(posedge clk);
        #1;
        got = {bus_b.pc, bus_b.pc_link, bus_b.fetch_valid,
               bus_b.flush, bus_b.halted};
`ifdef PC_WRAP_TRAP_EN
        checks++;
        if (got !== {10'h3FF, 10'h000, 3'b001} || bus_b.wrap_trap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_trap: got %h trap %b", got, bus_b.wrap_trap);
        end
        bus_b.redirect        = 1'b1;
        bus_b.redirect_target = 10'h010;
        @(posedge clk);
        #1;
        bus_b.redirect = 1'b0;
        got = {bus_b.pc, bus_b.pc_link, bus_b.fetch_valid,
               bus_b.flush, bus_b.halted};
        checks++;
        if (got !== {10'h010, 10'h011, 3'b110} || bus_b.wrap_trap !== 1'b1) begin
            errors++;
            $display("FAIL trap_redirect: got %h trap %b", got, bus_b.wrap_trap);
        end
`else
        checks++;
        if (got !== {10'h000, 10'h001, 3'b100}) begin
            errors++;
            $display("FAIL wrap_silent: got %h want %h", got,
                     {10'h000, 10'h001, 3'b100});
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        bus_a.redirect        = 1'b0;
        bus_a.redirect_target = '0;
        bus_a.halt_req        = 1'b0;
        bus_a.resume          = 1'b0;
        bus_a.fetch_ready     = 1'b1;
        bus_b.redirect        = 1'b0;
        bus_b.redirect_target = '0;
        bus_b.halt_req        = 1'b0;
        bus_b.resume          = 1'b0;
        bus_b.fetch_ready     = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt_resume();
        test_async_reset();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
